mmio_regfile_map: RTL and testbench
===================================

# mmio_regfile_map

Parametrised dual-port address decoder and MMIO register file in front of the shared SRAM. It splits each port's address space into a configurable bank of memory-mapped registers and an external SRAM window. It exposes the register contents and per-accelerator start/done handshakes to the matmul, matvec and maxpool engines. Each port has its own registered read-path select, and write collisions resolve deterministically.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- NUM_REGS, 16, number of MMIO registers (≥ NUM_ACCEL + FLAG_BASE)
- REG_STRIDE_LOG2, 8, log2 of register spacing (0x100)
- SRAM_BASE, 'h1000, first SRAM address; all lower addresses are the MMIO region
- NUM_ACCEL, 3, number of accelerator flag registers
- FLAG_BASE, 10, register index of accelerator 0's flag
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr_a / addr_b  in  ADDR_WIDTH  port address
- data_a / data_b  in  DATA_WIDTH  write data
- we_a / we_b  in  1  write enable
- q_a / q_b  out  DATA_WIDTH  read data, 1-cycle latency
- sram_we_a / sram_we_b  out  1  gated SRAM write enables; address and data pass through externally
- sram_q_a / sram_q_b  in  DATA_WIDTH  SRAM read data, valid 1 cycle after address
- regs_flat  out  NUM_REGS*DATA_WIDTH  current register values; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- start  out  NUM_ACCEL  one-cycle start pulse per accelerator
- done  in  NUM_ACCEL  one-cycle completion pulse per accelerator
- err_a / err_b  out  1  unmapped-access pulse

## Operation
- Decode per port:
  - addr ≥ SRAM_BASE → SRAM.
  - Otherwise idx = addr >> REG_STRIDE_LOG2. The access is a register hit only if idx < NUM_REGS and addr[REG_STRIDE_LOG2-1:0] == 0. Every other MMIO-region address is unmapped.
- SRAM writes: sram_we_x = we_x & SRAM-hit. Combinational; no register access occurs.
- Register writes: on rising edge, reg[idx] <= data_x when we_x and the access is a hit.
- Same-register collision: if both ports write the same idx in one cycle, port A's data is stored.
- Unmapped writes are dropped. Unmapped reads return 0.
- Reads return the old value, with read-before-write semantics on both paths.
  - Each port registers its own select: SRAM, REG, or NONE.
  - The mux is q_x = SRAM ? sram_q_x : REG ? rdreg_x : 0.
  - Port A's select never affects port B.
- Flag registers (idx FLAG_BASE+k, k < NUM_ACCEL):
  - A write of a nonzero value while the flag is 0 sets the flag to the written value.
  - start[k] pulses high for exactly the following cycle.
  - A write while the flag is nonzero updates the value but does not re-pulse start.
  - done[k] clears the flag to 0 on the next edge.
  - done[k] in the same cycle as a write to flag k: the done clear wins. No start pulse is issued.
- Non-flag registers change only through port writes.

## Timing
- Read latency is 1 cycle on both paths: addr in cycle N, q valid in cycle N+1, held until the next access edge.
- A register write in cycle N is visible on regs_flat after edge N. A port read of the same register in cycle N+1 returns the new value.
- start[k] is registered: it is high in cycle N+1 after a qualifying write in cycle N.
- err_x is registered: high in cycle N+1 for an unmapped access (read or write) in cycle N.
- Reset (asynchronous assert, synchronous release):
  - All registers = 0.
  - Read selects = NONE, so q_a = q_b = 0.
  - start = 0 and err = 0.
  - sram_we follows its inputs combinationally.
- Reset mid-operation aborts pending start pulses. Flags return to 0.

## Configuration
- MEMMAP_ERR_EN:
  - Defined: err_a and err_b are driven as specified.
  - Undefined: err_a and err_b are tied to 0 and the err logic is removed. Unmapped-access handling (write dropped, read returns 0) is unchanged.

## Test plan
- Reset: assert rst_n=0 mid-cycle → q_a=q_b=0, regs_flat=0, start=0 immediately.
- Register round-trip: A writes 'h1234 to 'h600, then reads 'h600 → q_a='h1234 one cycle after the read address. Port B reading 'h600 in the same cycle also returns 'h1234.
- Collision: A writes 'hAAAA and B writes 'hBBBB to 'h300 in the same cycle → the register reads 'hAAAA.
- Flag handshake: write 1 to 'hA00 → start[0]=1 for exactly one cycle. Rewrite 2 → no pulse. Pulse done[0] → 'hA00 reads 0.
- Unmapped access: read 'h0F80, and read 'h0E00 with NUM_REGS=14 → q=0, err_a=1 for one cycle (MEMMAP_ERR_EN defined). Without the macro, err_a stays 0.
- SRAM routing: A writes 'h55 to 'h1004 → sram_we_a=1 and no register changes. A reads 'h1004 while B reads 'h0600 in the same cycle → q_a=sram_q_a and q_b=reg[6], with no cross-port mux corruption.

Source files
------------

// File: rtl/mmio_regfile_map.sv
// mmio_regfile_map: dual-port address decoder and MMIO register file placed in
// front of the shared SRAM. Low addresses map to a strided bank of registers;
// addresses at or above SRAM_BASE go to the external SRAM. A small set of flag
// registers carries start/done handshakes for the accelerators.
// Optional feature macro: MEMMAP_ERR_EN (registered unmapped-access pulses on
// err_a/err_b; when undefined both outputs are tied low).
module mmio_regfile_map #(
   parameter int                     DATA_WIDTH      = 32,
   parameter int                     ADDR_WIDTH      = 32,
   parameter int                     NUM_REGS        = 16,
   parameter int                     REG_STRIDE_LOG2 = 8,
   parameter logic [ADDR_WIDTH-1:0]  SRAM_BASE       = 32'h0000_1000,
   parameter int                     NUM_ACCEL       = 3,
   parameter int                     FLAG_BASE       = 10
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          addr_a,
   input  logic [ADDR_WIDTH-1:0]          addr_b,
   input  logic [DATA_WIDTH-1:0]          data_a,
   input  logic [DATA_WIDTH-1:0]          data_b,
   input  logic                           we_a,
   input  logic                           we_b,
   output logic [DATA_WIDTH-1:0]          q_a,
   output logic [DATA_WIDTH-1:0]          q_b,
   output logic                           sram_we_a,
   output logic                           sram_we_b,
   input  logic [DATA_WIDTH-1:0]          sram_q_a,
   input  logic [DATA_WIDTH-1:0]          sram_q_b,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
   output logic [NUM_ACCEL-1:0]           start,
   input  logic [NUM_ACCEL-1:0]           done,
   output logic                           err_a,
   output logic                           err_b
);

   localparam int IDX_W = ADDR_WIDTH - REG_STRIDE_LOG2;
   localparam int RI_W  = $clog2(NUM_REGS);

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_SRAM = 2'd1;
   localparam logic [1:0] SEL_REG  = 2'd2;

   logic [DATA_WIDTH-1:0] regs_r     [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_nxt_s [NUM_REGS];
   logic [NUM_ACCEL-1:0]  start_nxt_s;
   logic [NUM_ACCEL-1:0]  start_r;

   logic                  sram_hit_a_s, sram_hit_b_s;
   logic                  reg_hit_a_s, reg_hit_b_s;
   logic [RI_W-1:0]       idx_a_s, idx_b_s;
   logic                  wr_a_s, wr_b_s;

   logic [1:0]            sel_a_r, sel_b_r;
   logic [DATA_WIDTH-1:0] rdreg_a_r, rdreg_b_r;

   // Address decode: SRAM window, aligned in-range register hit, else unmapped.
   always_comb begin
      sram_hit_a_s = (addr_a >= SRAM_BASE);
      sram_hit_b_s = (addr_b >= SRAM_BASE);
      reg_hit_a_s  = !sram_hit_a_s
                     && (addr_a[ADDR_WIDTH-1:REG_STRIDE_LOG2] < IDX_W'(NUM_REGS))
                     && (addr_a[REG_STRIDE_LOG2-1:0] == '0);
      reg_hit_b_s  = !sram_hit_b_s
                     && (addr_b[ADDR_WIDTH-1:REG_STRIDE_LOG2] < IDX_W'(NUM_REGS))
                     && (addr_b[REG_STRIDE_LOG2-1:0] == '0);
      idx_a_s      = addr_a[REG_STRIDE_LOG2 +: RI_W];
      idx_b_s      = addr_b[REG_STRIDE_LOG2 +: RI_W];
      wr_a_s       = we_a && reg_hit_a_s;
      wr_b_s       = we_b && reg_hit_b_s;
   end

   assign sram_we_a = we_a && sram_hit_a_s;
   assign sram_we_b = we_b && sram_hit_b_s;

   // Next register state: B first so A overrides on a same-index collision,
   // then done clears and start qualification on the flag registers.
   always_comb begin
      regs_nxt_s  = regs_r;
      start_nxt_s = '0;
      if (wr_b_s) begin
         regs_nxt_s[idx_b_s] = data_b;
      end else begin
         regs_nxt_s[idx_b_s] = regs_nxt_s[idx_b_s];
      end
      if (wr_a_s) begin
         regs_nxt_s[idx_a_s] = data_a;
      end else begin
         regs_nxt_s[idx_a_s] = regs_nxt_s[idx_a_s];
      end
      for (int k = 0; k < NUM_ACCEL; k++) begin
         if (done[k]) begin
            regs_nxt_s[FLAG_BASE+k] = '0;
            start_nxt_s[k]          = 1'b0;
         end else if (((wr_a_s && (idx_a_s == RI_W'(FLAG_BASE + k)))
                       || (wr_b_s && (idx_b_s == RI_W'(FLAG_BASE + k))))
                      && (regs_r[FLAG_BASE+k] == '0)
                      && (regs_nxt_s[FLAG_BASE+k] != '0)) begin
            start_nxt_s[k] = 1'b1;
         end else begin
            start_nxt_s[k] = 1'b0;
         end
      end
   end

   // Register bank, start pulses, per-port read selects and old-value capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
         start_r   <= '0;
         sel_a_r   <= SEL_NONE;
         sel_b_r   <= SEL_NONE;
         rdreg_a_r <= '0;
         rdreg_b_r <= '0;
      end else begin
         regs_r    <= regs_nxt_s;
         start_r   <= start_nxt_s;
         sel_a_r   <= sram_hit_a_s ? SEL_SRAM : (reg_hit_a_s ? SEL_REG : SEL_NONE);
         sel_b_r   <= sram_hit_b_s ? SEL_SRAM : (reg_hit_b_s ? SEL_REG : SEL_NONE);
         rdreg_a_r <= reg_hit_a_s ? regs_r[idx_a_s] : '0;
         rdreg_b_r <= reg_hit_b_s ? regs_r[idx_b_s] : '0;
      end
   end

   // Independent per-port read muxes driven by each port's own select.
   always_comb begin
      case (sel_a_r)
         SEL_SRAM: q_a = sram_q_a;
         SEL_REG:  q_a = rdreg_a_r;
         default:  q_a = '0;
      endcase
      case (sel_b_r)
         SEL_SRAM: q_b = sram_q_b;
         SEL_REG:  q_b = rdreg_b_r;
         default:  q_b = '0;
      endcase
   end

   assign start = start_r;

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
      end
   endgenerate

`ifdef MEMMAP_ERR_EN
   logic err_a_r, err_b_r;

   // Registered pulse for any access that hits neither SRAM nor a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_a_r <= 1'b0;
         err_b_r <= 1'b0;
      end else begin
         err_a_r <= !sram_hit_a_s && !reg_hit_a_s;
         err_b_r <= !sram_hit_b_s && !reg_hit_b_s;
      end
   end

   assign err_a = err_a_r;
   assign err_b = err_b_r;
`else
   assign err_a = 1'b0;
   assign err_b = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_regfile_map.sv
// Self-checking bench for mmio_regfile_map (built with NUM_REGS=14 so that
// index 14/15 addresses below the SRAM window are unmapped).
module tb_mmio_regfile_map;

   localparam int NREG = 14;
   localparam int FW   = NREG * 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     addr_a, addr_b, data_a, data_b;
   logic            we_a, we_b;
   logic [31:0]     q_a, q_b;
   logic            sram_we_a, sram_we_b;
   logic [31:0]     sram_q_a, sram_q_b;
   logic [FW-1:0]   regs_flat;
   logic [2:0]      start;
   logic [2:0]      done;
   logic            err_a, err_b;

   int total = 0;
   int bad   = 0;

   mmio_regfile_map #(.NUM_REGS(NREG)) dut (
      .clk(clk), .rst_n(rst_n),
      .addr_a(addr_a), .addr_b(addr_b),
      .data_a(data_a), .data_b(data_b),
      .we_a(we_a), .we_b(we_b),
      .q_a(q_a), .q_b(q_b),
      .sram_we_a(sram_we_a), .sram_we_b(sram_we_b),
      .sram_q_a(sram_q_a), .sram_q_b(sram_q_b),
      .regs_flat(regs_flat),
      .start(start), .done(done),
      .err_a(err_a), .err_b(err_b)
   );

   always #5 clk = ~clk;

`ifdef MEMMAP_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // kind: 0 unmapped, 1 SRAM, 2 register
   function automatic int decode(input logic [31:0] a, output int idx);
      idx = int'(a >> 8);
      if (a >= 32'h1000) return 1;
      if (a[7:0] == 8'h00 && idx < NREG) return 2;
      return 0;
   endfunction

   logic [31:0] m_regs [NREG];
   int          e_kind_a = 0, e_kind_b = 0;
   logic [31:0] e_rd_a = 32'h0, e_rd_b = 32'h0;
   logic [2:0]  e_start = 3'b000;
   logic        e_err_a = 1'b0, e_err_b = 1'b0;

   initial begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
            e_kind_a = 0; e_kind_b = 0; e_rd_a = 32'h0; e_rd_b = 32'h0;
            e_start = 3'b000; e_err_a = 1'b0; e_err_b = 1'b0;
         end else begin
            int ia, ib, ka, kb;
            logic [31:0] nr [NREG];
            logic [2:0] ns;
            ka = decode(addr_a, ia);
            kb = decode(addr_b, ib);
            e_kind_a = ka; e_kind_b = kb;
            e_rd_a   = (ka == 2) ? m_regs[ia] : 32'h0;
            e_rd_b   = (kb == 2) ? m_regs[ib] : 32'h0;
            e_err_a  = ERR_ON && (ka == 0);
            e_err_b  = ERR_ON && (kb == 0);
            ns = 3'b000;
            for (int i = 0; i < NREG; i++) begin
               bit wa, wb;
               wa = we_a && ka == 2 && ia == i;
               wb = we_b && kb == 2 && ib == i;
               nr[i] = wa ? data_a : (wb ? data_b : m_regs[i]);
               if (i >= 10 && i < 13) begin
                  if (done[i-10]) nr[i] = 32'h0;
                  else if ((wa || wb) && m_regs[i] == 32'h0 && nr[i] != 32'h0) ns[i-10] = 1'b1;
               end
            end
            for (int i = 0; i < NREG; i++) m_regs[i] = nr[i];
            e_start = ns;
         end
      end
   end

   // Every-cycle comparison against the model on the falling edge.
   initial begin
      @(posedge clk);
      forever begin
         logic [FW-1:0] ef;
         logic [31:0] eqa, eqb;
         @(negedge clk);
         for (int i = 0; i < NREG; i++) ef[i*32 +: 32] = m_regs[i];
         eqa = (e_kind_a == 1) ? sram_q_a : ((e_kind_a == 2) ? e_rd_a : 32'h0);
         eqb = (e_kind_b == 1) ? sram_q_b : ((e_kind_b == 2) ? e_rd_b : 32'h0);
         chk("q_a", FW'(q_a), FW'(eqa));
         chk("q_b", FW'(q_b), FW'(eqb));
         chk("regs_flat", regs_flat, ef);
         chk("start", FW'(start), FW'(e_start));
         chk("err_a", FW'(err_a), FW'(e_err_a));
         chk("err_b", FW'(err_b), FW'(e_err_b));
         chk("sram_we_a", FW'(sram_we_a), FW'(we_a && addr_a >= 32'h1000));
         chk("sram_we_b", FW'(sram_we_b), FW'(we_b && addr_b >= 32'h1000));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic [31:0] aa, input logic [31:0] da, input logic wa,
                      input logic [31:0] ab, input logic [31:0] db, input logic wb);
      addr_a = aa; data_a = da; we_a = wa;
      addr_b = ab; data_b = db; we_b = wb;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) return 32'($urandom_range(0, 15)) << 8;
      if (r == 5) return 32'($urandom_range(10, 12)) << 8;
      if (r == 6) return (32'($urandom_range(0, 15)) << 8) | 32'($urandom_range(1, 255));
      if (r <= 8) return 32'h1000 + 32'($urandom_range(0, 4095));
      return $urandom;
   endfunction

   function automatic logic [31:0] rand_data();
      if ($urandom_range(0, 3) == 0) return 32'h0;
      return $urandom;
   endfunction

   initial begin
      logic [FW-1:0] fexp;
      rst_n = 1'b0; done = 3'b000; sram_q_a = 32'h0; sram_q_b = 32'h0;
      drv(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_regs", regs_flat, '0);
      chk("reset_q_a", FW'(q_a), '0);
      chk("reset_start", FW'(start), '0);

      // register round-trip, both ports read the same register
      drv(32'h600, 32'h1234, 1'b1, 32'h0, 32'h0, 1'b0); step();
      drv(32'h600, 32'h0, 1'b0, 32'h600, 32'h0, 1'b0); step();
      chk("rt_q_a", FW'(q_a), FW'(32'h1234));
      chk("rt_q_b", FW'(q_b), FW'(32'h1234));

      // same-register collision: port A wins
      drv(32'h300, 32'hAAAA, 1'b1, 32'h300, 32'hBBBB, 1'b1); step();
      drv(32'h300, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("coll_q_a", FW'(q_a), FW'(32'hAAAA));

      // flag handshake on accelerator 0
      drv(32'hA00, 32'h1, 1'b1, 32'h0, 32'h0, 1'b0); step();
      chk("flag_start1", FW'(start), FW'(3'b001));
      drv(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("flag_start_off", FW'(start), FW'(3'b000));
      drv(32'hA00, 32'h2, 1'b1, 32'h0, 32'h0, 1'b0); step();
      chk("flag_rewrite", FW'(start), FW'(3'b000));
      drv(32'hA00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("flag_val2", FW'(q_a), FW'(32'h2));
      done = 3'b001;
      drv(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      done = 3'b000;
      drv(32'hA00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("flag_cleared", FW'(q_a), FW'(32'h0));

      // unmapped accesses
      drv(32'hF80, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("unm_f80_q", FW'(q_a), '0);
      chk("unm_f80_err", FW'(err_a), FW'(ERR_ON));
      drv(32'hE00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("unm_e00_q", FW'(q_a), '0);
      chk("unm_e00_err", FW'(err_a), FW'(ERR_ON));
      drv(32'hD00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); step();
      chk("map_d00_err", FW'(err_a), '0);

      // SRAM routing and per-port mux independence
      drv(32'h1004, 32'h55, 1'b1, 32'h0, 32'h0, 1'b0);
      #1 chk("sram_we_a_hit", FW'(sram_we_a), FW'(1'b1));
      step();
      fexp = '0;
      fexp[3*32 +: 32] = 32'hAAAA;
      fexp[6*32 +: 32] = 32'h1234;
      chk("sram_no_reg_change", regs_flat, fexp);
      drv(32'h1004, 32'h0, 1'b0, 32'h600, 32'h0, 1'b0); step();
      sram_q_a = 32'hCAFE_0001; sram_q_b = 32'h0BAD_0BAD;
      #1;
      chk("sram_q_a", FW'(q_a), FW'(32'hCAFE_0001));
      chk("reg_q_b", FW'(q_b), FW'(32'h1234));

      // reset in mid-operation aborts a pending start
      drv(32'hA00, 32'h5, 1'b1, 32'h600, 32'h0, 1'b0); step();
      chk("pre_rst_start", FW'(start), FW'(3'b001));
      chk("pre_rst_q_b", FW'(q_b), FW'(32'h1234));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_q_a", FW'(q_a), '0);
      chk("rst_q_b", FW'(q_b), '0);
      chk("rst_regs", regs_flat, '0);
      chk("rst_start", FW'(start), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drv(rand_addr(), rand_data(), 1'($urandom_range(0, 1)),
             rand_addr(), rand_data(), 1'($urandom_range(0, 1)));
         done     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         sram_q_a = $urandom;
         sram_q_b = $urandom;
         step();
         if (i == 1500) begin
            #2 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
